// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// the layout of the packed request-field bus.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

  // operation (1) + size (2) + extension (3)
  localparam int REQ_CTRL_W = 6;

  // Field bus layout, MSB first: {operation, size, extension, addr, data}
  function automatic int req_field_w(input int aw, input int dw);
    return REQ_CTRL_W + aw + dw;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One request slot: captures a requester's fields on its start pulse, holds them
// until the arbiter grants the slot, and flags starts that arrive at a bad time.
module mem_req_slot
  import mem_arbiter_pkg::*;
#(
  parameter int FW = req_field_w(64, 64)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [FW-1:0] fields,
  input  logic          clear,
  input  logic          in_flight,
  output logic          pending,
  output logic [FW-1:0] fields_q,
  output logic          err
);

  logic accept;

  // A port that is being served, or already has a request queued, may not start again.
  assign accept = start && !pending && !in_flight;
  assign err    = start && !accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      fields_q <= '0;
    end else if (accept) begin
      pending  <= 1'b1;
      fields_q <= fields;
    end else if (clear) begin
      pending  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_management unit between a processor
// port (0) and a loader/debug port (1), with a transaction watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_start,
  input  logic          r0_operation,
  input  logic [1:0]    r0_size,
  input  logic [2:0]    r0_extension,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_start,
  input  logic          r1_operation,
  input  logic [1:0]    r1_size,
  input  logic [2:0]    r1_extension,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_start,
  output logic          mem_operation,
  output logic [1:0]    mem_size,
  output logic [2:0]    mem_extension,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_i,
  output logic          owner,
  output logic          busy,
  output logic          proto_err,
  output logic          timeout_err
);

  localparam int FW = req_field_w(AW, DW);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    state, next_state;
  logic [1:0]    pending, slot_err, clear, in_flight, done_q;
  logic [FW-1:0] slot0_q, slot1_q, fwd_q;
  logic          last_grant, grant, grant_port, fire_done, fire_timeout;
  logic [CW-1:0] wd_cnt;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // The done cycle is already IDLE, so a port may re-request while its done pulse is out.
  assign in_flight[0] = (state != S_IDLE) && (owner == 1'b0);
  assign in_flight[1] = (state != S_IDLE) && (owner == 1'b1);

  mem_req_slot #(.FW(FW)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .start     (r0_start),
    .fields    ({r0_operation, r0_size, r0_extension, r0_addr, r0_data}),
    .clear     (clear[0]),
    .in_flight (in_flight[0]),
    .pending   (pending[0]),
    .fields_q  (slot0_q),
    .err       (slot_err[0])
  );

  mem_req_slot #(.FW(FW)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .start     (r1_start),
    .fields    ({r1_operation, r1_size, r1_extension, r1_addr, r1_data}),
    .clear     (clear[1]),
    .in_flight (in_flight[1]),
    .pending   (pending[1]),
    .fields_q  (slot1_q),
    .err       (slot_err[1])
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    grant        = 1'b0;
    grant_port   = 1'b0;
    clear        = '0;
    mem_start    = 1'b0;
    fire_done    = 1'b0;
    fire_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          grant             = 1'b1;
          grant_port        = (&pending) ? ~last_grant : pending[1];
          clear[grant_port] = 1'b1;
          next_state        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_start  = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          fire_done  = 1'b1;
          next_state = S_IDLE;
        end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
          fire_timeout = 1'b1;
          next_state   = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      fwd_q       <= '0;
      wd_cnt      <= '0;
      done_q      <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_q <= '0;
      wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
      if (|slot_err) proto_err <= 1'b1;
      if (grant) begin
        owner      <= grant_port;
        last_grant <= grant_port;
        fwd_q      <= grant_port ? slot1_q : slot0_q;
      end
      // An aborted load returns all-ones so the requester can tell it from real data.
      if (fire_done || fire_timeout) begin
        done_q[owner] <= 1'b1;
        if (owner) rdata1_q <= fire_done ? mem_i : '1;
        else       rdata0_q <= fire_done ? mem_i : '1;
      end
      if (fire_timeout) timeout_err <= 1'b1;
    end
  end

  assign busy     = (state != S_IDLE);
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;
  assign {mem_operation, mem_size, mem_extension, mem_addr, mem_data} = fwd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for single loads on each port,
// then hand-written sequences for fairness, protocol errors, timeout and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_start, r0_operation, r1_start, r1_operation;
  logic [1:0]  r0_size, r1_size;
  logic [2:0]  r0_extension, r1_extension;
  logic [63:0] r0_addr, r0_data, r1_addr, r1_data;
  logic        r0_done, r1_done;
  logic [63:0] r0_rdata, r1_rdata;
  logic        mem_start, mem_operation;
  logic [1:0]  mem_size;
  logic [2:0]  mem_extension;
  logic [63:0] mem_addr, mem_data;
  logic        mem_done;
  logic [63:0] mem_i;
  logic        owner, busy, proto_err, timeout_err;

  int n_vec  = 0;
  int n_fail = 0;
  int cnt0   = 0;
  int cnt1   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .r0_start(r0_start), .r0_operation(r0_operation), .r0_size(r0_size),
    .r0_extension(r0_extension), .r0_addr(r0_addr), .r0_data(r0_data),
    .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_start(r1_start), .r1_operation(r1_operation), .r1_size(r1_size),
    .r1_extension(r1_extension), .r1_addr(r1_addr), .r1_data(r1_data),
    .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_start(mem_start), .mem_operation(mem_operation), .mem_size(mem_size),
    .mem_extension(mem_extension), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_done(mem_done), .mem_i(mem_i),
    .owner(owner), .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          r0s, r1s, md;
    logic [31:0] mi;
    bit          e_ms, e_busy, e_owner, e_d0, e_d1;
    logic [15:0] e_addr;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input bit r0s, r1s, md, input logic [31:0] mi,
                              input bit ms, bz, ow, d0, d1, input logic [15:0] ad,
                              input logic [31:0] rd0, rd1);
    vec_t v;
    v.r0s = r0s; v.r1s = r1s; v.md = md; v.mi = mi;
    v.e_ms = ms; v.e_busy = bz; v.e_owner = ow; v.e_d0 = d0; v.e_d1 = d1;
    v.e_addr = ad; v.e_rd0 = rd0; v.e_rd1 = rd1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the bench drives and samples 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (r0_done) cnt0++;
    if (r1_done) cnt1++;
  endtask

  task automatic wait_mem_start(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_start) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_mem_start_seen"}, ok, 1);
  endtask

  // Entered in the ISSUE cycle; answers one cycle later and returns in the done cycle.
  task automatic serve(input logic [63:0] rd);
    step();
    mem_done = 1'b1;
    mem_i    = rd;
    step();
    mem_done = 1'b0;
    mem_i    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, b1;
    reset = 1'b1;
    r0_start = 0; r0_operation = 0; r0_size = 2'd3; r0_extension = 3'd1;
    r0_addr = 64'h100; r0_data = '0;
    r1_start = 0; r1_operation = 0; r1_size = 2'd2; r1_extension = 3'd4;
    r1_addr = 64'h200; r1_data = '0;
    mem_done = 0; mem_i = '0;
    step(); step();
    reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_mem_data", mem_data, 0);

    //          r0s r1s md mi            ms bz ow d0 d1 addr    rd0           rd1
    tbl[0]  = mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 0, 16'h000, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 16'h000, 32'h0,        32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h100, 32'h0,        32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 16'h100, 32'h0,        32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 16'h100, 32'h0,        32'h0);
    tbl[5]  = mk(0, 0, 1, 32'hDEADBEEF,  0, 1, 0, 0, 0, 16'h100, 32'h0,        32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 16'h100, 32'hDEADBEEF, 32'h0);
    tbl[7]  = mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 16'h100, 32'hDEADBEEF, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 16'h100, 32'hDEADBEEF, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0,         1, 1, 1, 0, 0, 16'h200, 32'hDEADBEEF, 32'h0);
    tbl[10] = mk(0, 0, 1, 32'h12345678,  0, 1, 1, 0, 0, 16'h200, 32'hDEADBEEF, 32'h0);
    tbl[11] = mk(0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 16'h200, 32'hDEADBEEF, 32'h12345678);
    tbl[12] = mk(0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 16'h200, 32'hDEADBEEF, 32'h12345678);

    for (int i = 0; i < 13; i++) begin
      r0_start = tbl[i].r0s;
      r1_start = tbl[i].r1s;
      mem_done = tbl[i].md;
      mem_i    = {32'h0, tbl[i].mi};
      check($sformatf("row%0d_mem_start", i), mem_start, tbl[i].e_ms);
      check($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("row%0d_owner", i), owner, tbl[i].e_owner);
      check($sformatf("row%0d_r0_done", i), r0_done, tbl[i].e_d0);
      check($sformatf("row%0d_r1_done", i), r1_done, tbl[i].e_d1);
      check($sformatf("row%0d_mem_addr", i), mem_addr, {48'h0, tbl[i].e_addr});
      check($sformatf("row%0d_mem_op", i), mem_operation, 0);
      check($sformatf("row%0d_r0_rdata", i), r0_rdata, {32'h0, tbl[i].e_rd0});
      check($sformatf("row%0d_r1_rdata", i), r1_rdata, {32'h0, tbl[i].e_rd1});
      step();
    end
    r0_start = 0; r1_start = 0; mem_done = 0; mem_i = '0;
    check("fields_size", mem_size, 2'd2);
    check("fields_ext", mem_extension, 3'd4);

    // Fairness: simultaneous stores, grants alternate 0,1,0,1,...
    for (int it = 0; it < 4; it++) begin
      r0_start = 1; r1_start = 1; r0_operation = 1; r1_operation = 1;
      r0_data = 64'hA000 + 64'(it); r1_data = 64'hB000 + 64'(it);
      r0_addr = 64'h1000 + 64'(it); r1_addr = 64'h2000 + 64'(it);
      step();
      r0_start = 0; r1_start = 0;
      for (int k = 0; k < 2; k++) begin
        wait_mem_start($sformatf("fair%0d_%0d", it, k));
        check($sformatf("fair%0d_%0d_owner", it, k), owner, k);
        check($sformatf("fair%0d_%0d_op", it, k), mem_operation, 1);
        check($sformatf("fair%0d_%0d_data", it, k), mem_data,
              (k == 1) ? 64'hB000 + 64'(it) : 64'hA000 + 64'(it));
        serve(64'h0);
        check($sformatf("fair%0d_%0d_done", it, k), k ? r1_done : r0_done, 1);
      end
      step();
    end
    r0_operation = 0; r1_operation = 0;

    // Restart on the done cycle is accepted and reissued two cycles later.
    r0_start = 1; r0_addr = 64'h680;
    step();
    r0_start = 0;
    wait_mem_start("redo_a");
    serve(64'h7777);
    check("redo_done", r0_done, 1);
    r0_start = 1; r0_addr = 64'h700;
    step();
    r0_start = 0;
    check("redo_no_start_yet", mem_start, 0);
    check("redo_no_proto_err", proto_err, 0);
    step();
    check("redo_mem_start", mem_start, 1);
    check("redo_mem_addr", mem_addr, 64'h700);
    serve(64'h7070);
    check("redo_rdata", r0_rdata, 64'h7070);
    check("redo_proto_err_clear", proto_err, 0);
    step();

    // Port 1 restarts while in WAIT; port 0 queues alongside.
    b0 = cnt0; b1 = cnt1;
    r1_start = 1; r1_addr = 64'h300;
    step();
    r1_start = 0;
    wait_mem_start("perr");
    check("perr_owner1", owner, 1);
    step();
    r1_start = 1; r1_addr = 64'h3F0; r0_start = 1; r0_addr = 64'h400;
    step();
    r1_start = 0; r0_start = 0;
    check("perr_proto_err", proto_err, 1);
    mem_done = 1; mem_i = 64'h1111;
    step();
    mem_done = 0; mem_i = '0;
    check("perr_r1_done", r1_done, 1);
    check("perr_r1_rdata", r1_rdata, 64'h1111);
    step();
    wait_mem_start("perr_p0");
    check("perr_p0_owner", owner, 0);
    check("perr_p0_addr", mem_addr, 64'h400);
    serve(64'h2222);
    check("perr_p0_done", r0_done, 1);
    check("perr_p0_rdata", r0_rdata, 64'h2222);
    for (int i = 0; i < 6; i++) step();
    check("perr_idle", busy, 0);
    check("perr_r1_done_count", cnt1 - b1, 1);
    check("perr_r0_done_count", cnt0 - b0, 1);

    // Watchdog: memory never answers.
    b0 = cnt0;
    r0_start = 1; r0_addr = 64'h500;
    step();
    r0_start = 0;
    wait_mem_start("wd");
    step();
    for (int i = 1; i < 8; i++) step();
    check("wd_not_yet", r0_done, 0);
    check("wd_err_not_yet", timeout_err, 0);
    step();
    check("wd_done", r0_done, 1);
    check("wd_rdata", r0_rdata, {64{1'b1}});
    check("wd_err", timeout_err, 1);
    check("wd_busy", busy, 0);
    mem_done = 1; mem_i = 64'h9999;
    step();
    mem_done = 0; mem_i = '0;
    check("wd_late_no_done", r0_done, 0);
    check("wd_late_rdata", r0_rdata, {64{1'b1}});
    check("wd_late_busy", busy, 0);
    r0_start = 1; r0_addr = 64'h600;
    step();
    r0_start = 0;
    wait_mem_start("wd_next");
    check("wd_next_addr", mem_addr, 64'h600);
    serve(64'h600D);
    check("wd_next_done", r0_done, 1);
    check("wd_next_rdata", r0_rdata, 64'h600D);
    check("wd_err_sticky", timeout_err, 1);
    check("wd_done_count", cnt0 - b0, 2);
    step();

    // Reset mid-WAIT abandons the transaction.
    b0 = cnt0;
    r0_start = 1; r0_addr = 64'h800;
    step();
    r0_start = 0;
    wait_mem_start("rst");
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_owner", owner, 0);
    check("rst_mid_mem_start", mem_start, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_r0_rdata", r0_rdata, 0);
    check("rst_mid_r1_rdata", r1_rdata, 0);
    check("rst_mid_proto_err", proto_err, 0);
    check("rst_mid_timeout_err", timeout_err, 0);
    for (int i = 0; i < 10; i++) step();
    check("rst_no_done", cnt0 - b0, 0);
    r0_start = 1; r1_start = 1; r0_addr = 64'h900; r1_addr = 64'hA00;
    step();
    r0_start = 0; r1_start = 0;
    wait_mem_start("rst_after");
    check("rst_after_owner", owner, 0);
    check("rst_after_addr", mem_addr, 64'h900);
    serve(64'h4242);
    check("rst_after_done", r0_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
